// File: rtl/kyber_pkg.sv
// Constants, loader state encoding and index helpers shared by the Kyber
// polynomial front-end and the NTT core.
package kyber_pkg;

    localparam int KYBER_Q    = 3329;
    localparam int KYBER_N    = 256;
    localparam int COEFF_W    = 12;
    localparam int LANES      = 8;
    localparam int WORD_W     = 96;
    localparam int RAM_ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } load_state_t;

    function automatic logic [4:0] bitrev5(input logic [4:0] x);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

endpackage

// File: rtl/mod_q_csub.sv
// Conditional subtract of Q: maps any input below 2Q into [0, Q).
module mod_q_csub #(
    parameter int Q = kyber_pkg::KYBER_Q,
    parameter int W = kyber_pkg::COEFF_W
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    localparam logic [W-1:0] QV = W'(Q);

    assign y = (x >= QV) ? (x - QV) : x;

endmodule

// File: rtl/ntt_poly_loader.sv
// Collects 256 natural-order coefficients, reduces them mod q, scatters them into the
// bit-reversed 8-lane word layout of the NTT core and burst-writes 32 words to RAM.
module ntt_poly_loader #(
    parameter int Q       = kyber_pkg::KYBER_Q,
    parameter int COEFF_W = kyber_pkg::COEFF_W,
    parameter int LANES   = kyber_pkg::LANES,
    parameter int ADDR_W  = kyber_pkg::RAM_ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          w_data_addr_offset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [COEFF_W-1:0]         in_coeff,
    output logic                       w_data_en,
    output logic [ADDR_W-1:0]          w_data_addr,
    output logic [LANES*COEFF_W-1:0]   w_data,
    output logic                       busy,
    output logic                       done
);

    import kyber_pkg::*;

    localparam int WORD_BITS = LANES * COEFF_W;
    localparam int N_WORDS   = KYBER_N / LANES;

    load_state_t           state;
    logic [7:0]            n;
    logic [4:0]            k;
    logic [ADDR_W-1:0]     offset;
    logic [WORD_BITS-1:0]  buffer [N_WORDS];

    logic                  accept;
    logic [COEFF_W-1:0]    red_coeff;
    logic [4:0]            fill_word;
    logic [2:0]            fill_lane;
    logic [4:0]            k_next;

    // Handshake: a coefficient transfers on every rising edge where in_valid && in_ready;
    // in_ready depends on state only, so in_valid may be held or dropped freely.
    assign in_ready  = (state == ST_FILL);
    assign busy      = (state != ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign fill_word = bitrev5(n[5:1]);
    assign fill_lane = {n[6], n[7], n[0]};
    assign k_next    = k + 5'd1;

    mod_q_csub #(
        .Q (Q),
        .W (COEFF_W)
    ) u_csub (
        .x (in_coeff),
        .y (red_coeff)
    );

    // Buffer is deliberately unreset: every lane is rewritten before each flush.
    always_ff @(posedge clk) begin
        if (accept) begin
            buffer[fill_word][fill_lane*COEFF_W +: COEFF_W] <= red_coeff;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            n           <= '0;
            k           <= '0;
            offset      <= '0;
            w_data_en   <= 1'b0;
            w_data_addr <= '0;
            w_data      <= '0;
            done        <= 1'b0;
        end else begin
            w_data_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_FILL;
                        offset <= w_data_addr_offset;
                        n      <= '0;
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        n <= n + 8'd1;
                        // Word 0 never holds index 255, so it is complete and can be
                        // launched on the same edge as the final accept.
                        if (n == 8'd255) begin
                            state       <= ST_FLUSH;
                            k           <= '0;
                            w_data_en   <= 1'b1;
                            w_data_addr <= offset;
                            w_data      <= buffer[0];
                        end
                    end
                end
                ST_FLUSH: begin
                    // k tracks the word currently presented on the write port.
                    if (k == 5'd31) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        k           <= k_next;
                        w_data_en   <= 1'b1;
                        w_data_addr <= offset + ADDR_W'(k_next);
                        w_data      <= buffer[k_next];
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
